// File: rtl/fft_out_serializer.sv
// fft_out_serializer: snapshots one frame of NPTS complex FFT results on
// readyin and streams them as 2*NPTS words (re, im per point) over a
// valid/ready handshake. Supports stalls, back-to-back frames and a sticky
// overrun flag for frames that arrive while a stream is in progress.
// Optional macro FFT_OUT_BITREV_EN: emit points in bit-reversed order.
module fft_out_serializer #(
  parameter int WIDTH = 8,
  parameter int NPTS  = 4
) (
  input  logic                  clock,
  input  logic                  n_rst,
  input  logic                  readyin,
  input  logic [NPTS*WIDTH-1:0] din_re,
  input  logic [NPTS*WIDTH-1:0] din_im,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  output logic                  y_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int PW = $clog2(NPTS);
  localparam int IW = PW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * NPTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nx;
  logic [PW-1:0]     pt_nx;
  logic [WIDTH-1:0]  word_nx;
  logic [WIDTH-1:0]  snap_re [NPTS];
  logic [WIDTH-1:0]  snap_im [NPTS];
  logic              xfer;
  logic              capture;
  logic              advance;
  logic              drop;

  // Map a word index to the snapshot point it reads from.
  function automatic logic [PW-1:0] point_of(input logic [IW-1:0] i);
    logic [PW-1:0] k;
    logic [PW-1:0] r;
    k = i[IW-1:1];
`ifdef FFT_OUT_BITREV_EN
    for (int b = 0; b < PW; b++) r[b] = k[PW-1-b];
`else
    r = k;
`endif
    return r;
  endfunction

  assign y_valid = (state == STREAM);
  assign busy    = y_valid;
  assign y_last  = y_valid && (idx == LAST_IDX);
  assign xfer    = y_valid && out_ready;

  // Next word after the current one: even index is real, odd is imaginary.
  assign idx_nx  = idx + 1'b1;
  assign pt_nx   = point_of(idx_nx);
  assign word_nx = idx_nx[0] ? snap_im[pt_nx] : snap_re[pt_nx];

  // Next-state and control decode for the IDLE/STREAM sequencer.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    advance  = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (readyin) begin
          capture  = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        if (xfer && (idx == LAST_IDX)) begin
          if (readyin) capture  = 1'b1;
          else         state_nx = IDLE;
        end else begin
          advance = xfer;
          drop    = readyin;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Word counter, output word and sticky overrun flag.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      idx     <= '0;
      y       <= '0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        // Point 0 is first in both natural and bit-reversed order.
        idx <= '0;
        y   <= din_re[WIDTH-1:0];
      end else if (advance) begin
        idx <= idx_nx;
        y   <= word_nx;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  // Frame snapshot; pure data, so it carries no reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int p = 0; p < NPTS; p++) begin
        snap_re[p] <= din_re[p*WIDTH +: WIDTH];
        snap_im[p] <= din_im[p*WIDTH +: WIDTH];
      end
    end
  end

endmodule
